// File: rtl/dmac_fifo_pkg.sv
// dmac_fifo_pkg: shared widths, defaults and count type
// for the DMAC FWFT buffering FIFO.
package dmac_fifo_pkg;

  localparam int DEPTH_LG2_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 32;

  function automatic int ptr_width(input int lg2);
    return lg2 + 1;
  endfunction

  function automatic int cnt_width(input int lg2);
    return lg2 + 1;
  endfunction

  typedef logic [cnt_width(DEPTH_LG2_DEF)-1:0] cnt_t;

endpackage

// File: rtl/dmac_fifo_mem.sv
// dmac_fifo_mem: one write port, async read port.
// No reset so it can map onto distributed RAM.
module dmac_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wren_i,
  input  logic [AW-1:0] wraddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] rdaddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (wren_i) mem_q[wraddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[rdaddr_i];

endmodule

// File: rtl/dmac_fifo_fwft.sv
// dmac_fifo_fwft: FWFT FIFO with count, watermarks, flush.
// Optional sticky ovf/udf flags with DMAC_FIFO_ERR_EN.
module dmac_fifo_fwft
  import dmac_fifo_pkg::*;
#(
  parameter int DEPTH_LG2  = DEPTH_LG2_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DMAC_FIFO_ERR_EN
  input  logic                  err_clr_i,
  output logic                  ovf_o,
  output logic                  udf_o,
`endif
  input  logic                  flush_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [DEPTH_LG2:0]    count_o
);

  localparam int DEPTH = 2**DEPTH_LG2;
  localparam int PW    = ptr_width(DEPTH_LG2);
  localparam int CW    = cnt_width(DEPTH_LG2);
  localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LVL = CW'(AE_MARGIN);
  localparam logic AF_RST = (DEPTH - AF_MARGIN) <= 0;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic push, pop;

  assign push = wren_i & ~full_q & ~flush_i;
  assign pop  = rden_i & ~empty_q & ~flush_i;

  dmac_fifo_mem #(
    .AW(DEPTH_LG2),
    .DW(DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wren_i  (push),
    .wraddr_i(wptr_q[DEPTH_LG2-1:0]),
    .wdata_i (wdata_i),
    .rdaddr_i(rptr_d[DEPTH_LG2-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      unique case (1'b1)
        push & ~pop: cnt_d = cnt_q + CW'(1);
        pop & ~push: cnt_d = cnt_q - CW'(1);
        default:     cnt_d = cnt_q;
      endcase
    end
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[DEPTH_LG2] != rptr_d[DEPTH_LG2]) &&
              (wptr_d[DEPTH_LG2-1:0] == rptr_d[DEPTH_LG2-1:0]);
    af_d    = (cnt_d >= AF_LVL);
    ae_d    = (cnt_d <= AE_LVL);
    // New head is the entry being written now: bypass the array
    rdata_d = rdata_q;
    if (!empty_d) begin
      if (push && (rptr_d == wptr_q)) rdata_d = wdata_i;
      else                            rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AF_RST;
      ae_q    <= 1'b1;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMAC_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i || err_clr_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wren_i && full_q)  ovf_q <= 1'b1;
      if (rden_i && empty_q) udf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = cnt_q;
  assign rdata_o        = rdata_q;

endmodule

// File: tb/tb_dmac_fifo_fwft.sv
// tb_dmac_fifo_fwft: vector table, corner sequences and
// randomized traffic against a queue reference model.
module tb_dmac_fifo_fwft;
  import dmac_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        wren_i;
  logic        rden_i;
  logic        err_clr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        full_o;
  logic        almost_full_o;
  logic        empty_o;
  logic        almost_empty_o;
  cnt_t        count_o;
`ifdef DMAC_FIFO_ERR_EN
  logic        ovf_o;
  logic        udf_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  bit ovf_m, udf_m;

  typedef struct {
    bit          fl;
    bit          wr;
    bit          rd;
    logic [31:0] wd;
    int          ecnt;
    bit          eempty;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  dmac_fifo_fwft dut (
    .clk           (clk),
    .rst           (rst),
`ifdef DMAC_FIFO_ERR_EN
    .err_clr_i     (err_clr_i),
    .ovf_o         (ovf_o),
    .udf_o         (udf_o),
`endif
    .flush_i       (flush_i),
    .wren_i        (wren_i),
    .wdata_i       (wdata_i),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .rden_i        (rden_i),
    .rdata_o       (rdata_o),
    .empty_o       (empty_o),
    .almost_empty_o(almost_empty_o),
    .count_o       (count_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count", 32'(count_o), 32'(n));
    chk("empty", 32'(empty_o), 32'(n == 0));
    chk("full", 32'(full_o), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full_o), 32'(n >= DEPTH - 2));
    chk("almost_empty", 32'(almost_empty_o), 32'(n <= 2));
    if (n > 0) chk("head", rdata_o, q[0]);
`ifdef DMAC_FIFO_ERR_EN
    chk("ovf", 32'(ovf_o), 32'(ovf_m));
    chk("udf", 32'(udf_o), 32'(udf_m));
`endif
  endtask

  task automatic step(input bit fl, input bit wr,
                      input logic [31:0] wd, input bit rd);
    bit pa, po, was_full, was_empty;
    flush_i = fl;
    wren_i  = wr;
    wdata_i = wd;
    rden_i  = rd;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (fl || err_clr_i) begin
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end else begin
      if (wr && was_full)  ovf_m = 1'b1;
      if (rd && was_empty) udf_m = 1'b1;
    end
    if (fl) begin
      q.delete();
    end else begin
      pa = wr && !was_full;
      po = rd && !was_empty;
      if (po) void'(q.pop_front());
      if (pa) q.push_back(wd);
    end
    #1;
    flush_i   = 1'b0;
    wren_i    = 1'b0;
    rden_i    = 1'b0;
    err_clr_i = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush_i   = 1'b0;
    wren_i    = 1'b0;
    rden_i    = 1'b0;
    err_clr_i = 1'b0;
    wdata_i   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, 1, 0, 32'hA5A5_0001, 1, 0, 32'hA5A5_0001};
    tbl[1] = '{0, 1, 0, 32'h0000_0002, 2, 0, 32'hA5A5_0001};
    tbl[2] = '{0, 0, 1, 32'h0,         1, 0, 32'h0000_0002};
    tbl[3] = '{0, 1, 1, 32'h0000_0003, 1, 0, 32'h0000_0003};
    tbl[4] = '{1, 1, 0, 32'h0000_0004, 0, 1, 32'h0};
    tbl[5] = '{0, 0, 1, 32'h0,         0, 1, 32'h0};
    tbl[6] = '{0, 1, 0, 32'h0000_0077, 1, 0, 32'h0000_0077};
    tbl[7] = '{0, 0, 1, 32'h0,         0, 1, 32'h0};

    do_reset();
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_ae", 32'(almost_empty_o), 1);
    chk("rst_af", 32'(almost_full_o), 0);
    chk("rst_rdata", rdata_o, 0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].fl, tbl[i].wr, tbl[i].wd, tbl[i].rd);
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(tbl[i].eempty));
      if (!tbl[i].eempty)
        chk($sformatf("vec%0d_rdata", i), rdata_o, tbl[i].erd);
      if (i == 0) chk("first_ae", 32'(almost_empty_o), 1);
    end

    // fill / drain in order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 32'(i), 0);
      chk("fill_af", 32'(almost_full_o), 32'(i + 1 >= 14));
    end
    chk("full16", 32'(full_o), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_head", rdata_o, 32'(i));
      step(0, 0, 0, 1);
    end
    chk("drained_empty", 32'(empty_o), 1);

    // simultaneous push/pop at full and at empty
    for (int i = 0; i < 16; i++) step(0, 1, 32'(100 + i), 0);
`ifdef DMAC_FIFO_ERR_EN
    step(0, 1, 32'hBEEF, 0);
    chk("ovf_set", 32'(ovf_o), 1);
    step(0, 0, 0, 0);
    chk("ovf_sticky", 32'(ovf_o), 1);
    err_clr_i = 1'b1;
    step(0, 0, 0, 0);
    chk("ovf_clr", 32'(ovf_o), 0);
`endif
    step(0, 1, 32'hDEAD, 1);
    chk("full_wr_rd_count", 32'(count_o), 15);
    chk("full_wr_rd_head", rdata_o, 101);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1);
`ifdef DMAC_FIFO_ERR_EN
    step(0, 0, 0, 1);
    chk("udf_set", 32'(udf_o), 1);
`endif
    step(0, 1, 32'hDEAD, 1);
    chk("empty_wr_rd_count", 32'(count_o), 1);
    chk("empty_wr_rd_rdata", rdata_o, 32'hDEAD);

    // pointer wrap at count 1
    do_reset();
    step(0, 1, 32'd1000, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 32'(2000 + i), 1);
      chk("wrap_head", rdata_o, 32'(2000 + i));
    end

    // flush with concurrent push
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 1, 32'(300 + i), 0);
    step(1, 1, 32'h55, 0);
    chk("flush_count", 32'(count_o), 0);
    chk("flush_empty", 32'(empty_o), 1);
    step(0, 1, 32'h77, 0);
    chk("post_flush_rdata", rdata_o, 32'h77);

    // randomized traffic with varying bias
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int pw;
      pw = (i / 100) % 2 == 0 ? 70 : 30;
      err_clr_i = ($urandom_range(99) < 5);
      step($urandom_range(99) == 0,
           $urandom_range(99) < pw,
           $urandom,
           $urandom_range(99) < 100 - pw);
    end

    // reset mid-burst, then a normal push
    for (int i = 0; i < 5; i++) step(0, 1, 32'(500 + i), 0);
    do_reset();
    check_model();
    step(0, 1, 32'h600, 0);
    chk("post_rst_push", rdata_o, 32'h600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
